// File: rtl/data_memory_responder.sv
// Responder end of the core data-memory handshake: word storage with byte-enable writes,
// a fixed wait-state delay, and a one-cycle ready strobe carrying read data or an error flag.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SpanB    = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic [31:0]     acc_off;
    logic [IdxW-1:0] acc_idx;
    logic            acc_err;
    logic            commit;

    // With zero wait states the access commits on the accepting edge, so it uses live inputs.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_off = acc_addr - BASE_ADDR;
        acc_idx = acc_off[IdxW+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_off >= SpanB);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = '0;
        err_d   = 1'b0;
        commit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (commit) begin
            err_d = acc_err;
            if (!acc_err && !acc_we) begin
                rdata_d = mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; contents survive reset and are undefined at power-up.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state_q == StResp);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: three instances (1, 3 and 0 wait states, the last
// with a non-zero base address), a vector table plus hand sequences for multi-cycle cases.
module tb_data_memory_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_s   [3];
    logic        we_s    [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [3:0]  be_s    [3];
    logic [31:0] rdata_s [3];
    logic        ready_s [3];
    logic        err_s   [3];

    data_memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u_ws1 (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .be(be_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0])
    );
    data_memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3), .BASE_ADDR(32'h0000_0000)) u_ws3 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .be(be_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1])
    );
    data_memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) u_ws0 (
        .clk(clk), .reset(reset), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .be(be_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .err(err_s[2])
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int ws_of [3] = '{1, 3, 0};

    typedef struct {
        int          inst;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] rd;
        logic        e;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int inst, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] rd, input logic e,
                       input string name);
        vec_t v;
        v.inst = inst; v.w = w; v.a = a; v.d = d; v.b = b; v.rd = rd; v.e = e; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge; counts further edges until ready is seen (bounded).
    task automatic wait_ready(input int i, output int n);
        n = 0;
        while (ready_s[i] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err,
                          input string name);
        int n;
        req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d; be_s[i] = b;
        @(posedge clk);
        #1;
        req_s[i] = 1'b0;
        wait_ready(i, n);
        check({name, " latency"}, 32'(n), 32'(ws_of[i]));
        check({name, " rdata"}, rdata_s[i], exp_rd);
        check({name, " err"}, {31'b0, err_s[i]}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        check({name, " ready drop"}, {31'b0, ready_s[i]}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic        exp_rdy;
        logic [31:0] exp_e [7];

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0; be_s[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset ready i%0d", i), {31'b0, ready_s[i]}, 32'd0);
            check($sformatf("reset err i%0d", i), {31'b0, err_s[i]}, 32'd0);
            check($sformatf("reset rdata i%0d", i), rdata_s[i], 32'd0);
        end
        pulse_reset();

        add(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        0, "w1 write 0x10");
        add(0, 0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 0, "w1 read 0x10");
        add(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0,        0, "w1 write 0x20 full");
        add(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0,        0, "w1 write 0x20 be5");
        add(0, 0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD, 0, "w1 read 0x20 merged");
        add(0, 1, 32'h0,  32'hCAFEF00D, 4'hF, 32'h0,        0, "w1 write 0x0");
        add(0, 0, 32'h22, 32'h0,        4'hF, 32'h0,        1, "w1 read misaligned");
        add(0, 0, 32'h100, 32'h0,       4'hF, 32'h0,        1, "w1 read out of range");
        add(0, 1, 32'h2,  32'h12345678, 4'hF, 32'h0,        1, "w1 write misaligned");
        add(0, 1, 32'h0,  32'hFFFFFFFF, 4'h0, 32'h0,        0, "w1 write be0");
        add(0, 0, 32'h0,  32'h0,        4'hF, 32'hCAFEF00D, 0, "w1 read 0x0 unchanged");
        add(0, 1, 32'hFC, 32'h0A0B0C0D, 4'hF, 32'h0,        0, "w1 write last word");
        add(0, 0, 32'hFC, 32'h0,        4'hF, 32'h0A0B0C0D, 0, "w1 read last word");
        add(0, 0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, "w1 read ignores be");
        add(1, 1, 32'h4,  32'h01020304, 4'hF, 32'h0,        0, "w3 write 0x4");
        add(2, 1, 32'h1000, 32'h11111111, 4'hF, 32'h0,      0, "w0 write base");
        add(2, 1, 32'h1004, 32'h22222222, 4'hF, 32'h0,      0, "w0 write base+4");
        add(2, 0, 32'h0FFC, 32'h0,      4'hF, 32'h0,        1, "w0 read below base");
        add(2, 0, 32'h1100, 32'h0,      4'hF, 32'h0,        1, "w0 read past end");
        add(2, 1, 32'h10FC, 32'h0BADF00D, 4'hF, 32'h0,      0, "w0 write last word");
        add(2, 0, 32'h10FC, 32'h0,      4'hF, 32'h0BADF00D, 0, "w0 read last word");

        foreach (vecs[k]) begin
            access(vecs[k].inst, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].b,
                   vecs[k].rd, vecs[k].e, vecs[k].name);
        end

        // req held high with one wait state: accepts on edges 1,4,7, ready after 2,5,8.
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10; be_s[0] = 4'h0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            exp_rdy = (k % 3 == 2);
            check($sformatf("held w1 ready e%0d", k), {31'b0, ready_s[0]}, {31'b0, exp_rdy});
            if (exp_rdy) check($sformatf("held w1 rdata e%0d", k), rdata_s[0], 32'hDEADBEEF);
            if (k == 8) req_s[0] = 1'b0;
        end

        // Inputs changed during WAIT must not affect the committed write.
        req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h8; wdata_s[1] = 32'h55AA55AA;
        be_s[1] = 4'hF;
        @(posedge clk);
        #1;
        req_s[1] = 1'b0; we_s[1] = 1'b0; addr_s[1] = 32'hC; wdata_s[1] = 32'h0; be_s[1] = 4'h0;
        wait_ready(1, n);
        check("w3 changed-input latency", 32'(n), 32'd3);
        check("w3 changed-input err", {31'b0, err_s[1]}, 32'd0);
        @(posedge clk);
        #1;
        access(1, 0, 32'h8, 32'h0, 4'hF, 32'h55AA55AA, 0, "w3 read 0x8");

        // Reset while the write to 0x4 is still waiting.
        req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h4; wdata_s[1] = 32'hFFFFFFFF;
        be_s[1] = 4'hF;
        @(posedge clk);
        #1;
        req_s[1] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("wait reset ready", {31'b0, ready_s[1]}, 32'd0);
        check("wait reset err", {31'b0, err_s[1]}, 32'd0);
        check("wait reset rdata", rdata_s[1], 32'd0);
        @(posedge clk);
        pulse_reset();
        access(1, 0, 32'h4, 32'h0, 4'hF, 32'h01020304, 0, "w3 read after reset");

        // Reset during the response cycle clears outputs without a clock edge.
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10;
        @(posedge clk);
        #1;
        req_s[0] = 1'b0;
        wait_ready(0, n);
        check("resp reset pre rdata", rdata_s[0], 32'hDEADBEEF);
        reset = 1'b0;
        #1;
        check("resp reset ready", {31'b0, ready_s[0]}, 32'd0);
        check("resp reset rdata", rdata_s[0], 32'd0);
        pulse_reset();
        access(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, "w1 read after reset");

        // Zero wait states, req held: ready every other cycle.
        exp_e[1] = 32'h11111111; exp_e[3] = 32'h22222222; exp_e[5] = 32'h11111111;
        req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 32'h1000; be_s[2] = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            exp_rdy = (k % 2 == 1);
            check($sformatf("held w0 ready e%0d", k), {31'b0, ready_s[2]}, {31'b0, exp_rdy});
            if (exp_rdy) check($sformatf("held w0 rdata e%0d", k), rdata_s[2], exp_e[k]);
            if (k == 1) addr_s[2] = 32'h1004;
            if (k == 3) addr_s[2] = 32'h1000;
            if (k == 6) req_s[2] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the processor data-memory interface: accepts read/write requests from the core, adds a configurable wait-state count, then returns a single-cycle ready with read data or an error flag.
- Replaces the zero-latency data memory where the core is extended with a request/ready handshake.
- Word-organised storage with byte-enable writes, address-range and alignment checking.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 4.
- WAIT_STATES, 1, extra cycles between request acceptance and response; 0 to 15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 4*DEPTH_WORDS-aligned.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- req  in  1  access request from core; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  write data; sampled with req.
- be  in  4  byte enables, be[i] selects wdata[8i+7:8i]; writes only.
- rdata  out  32  read data; valid only while ready=1.
- ready  out  1  response strobe, high exactly one cycle per accepted request.
- err  out  1  error qualifier, valid only while ready=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, ready=0, err=0, rdata=0. Memory contents are not cleared and are undefined after power-up. A request not yet committed is dropped, with no write and no response. Release is synchronous to clk.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1 at a rising edge t0, latch we/addr/wdata/be and accept.
  - WAIT_STATES=0: go to RESP.
  - Otherwise: go to WAIT with counter=WAIT_STATES-1.
- WAIT: inputs are ignored, so changing or dropping req does not cancel the access.
  - counter>0: decrement.
  - counter=0: go to RESP.
- Commit: on the edge entering RESP (edge t0+WAIT_STATES), the access executes against the latched request.
  - Read: rdata <= mem[idx].
  - Write: each byte lane with be[i]=1 is updated; rdata <= 0.
- RESP: ready=1, err as computed, for exactly one cycle. The next edge returns to IDLE with ready=0, err=0, rdata=0.
- Latency: ready is high during the cycle after edge t0+WAIT_STATES. Minimum spacing between acceptances is WAIT_STATES+2 edges. A req held high is re-accepted in IDLE on the edge after RESP as a new access.
- Address decode: off = addr - BASE_ADDR (32-bit wrap-around arithmetic); idx = off[log2(DEPTH_WORDS)+1:2].
- Error when addr[1:0]!=0 or off >= 4*DEPTH_WORDS. On error:
  - no memory change and rdata=0;
  - err=1 with ready=1;
  - timing is identical to a normal access.
- Write with be=4'b0000: no memory change; ready=1, err=0.
- Reads ignore be and always return the full word.
- Write followed by read of the same address returns the new data.

Test Plan:
- WAIT_STATES=1. Write addr=0x10, wdata=0xDEADBEEF, be=4'hF; then read 0x10. -> ready high in the 2nd cycle after each acceptance; read rdata=0xDEADBEEF, err=0; acceptances 3 edges apart with req held high.
- Byte enables. Write 0x11223344 to 0x20 with be=F, then 0xAABBCCDD with be=4'b0101, then read. -> rdata=0x11BB33DD.
- Errors. Read 0x22 (misaligned) and 0x100 (out of range, DEPTH_WORDS=64). -> ready=1, err=1, rdata=0; a prior write to word 0 is unchanged.
- Mid-access input changes. WAIT_STATES=3: accept a write to 0x8, then drop req and change addr/wdata during WAIT. -> the original write commits; ready appears exactly 4 cycles after acceptance.
- Reset mid-operation. Assert reset=0 while in WAIT during a write. -> ready/err/rdata go to 0 immediately; the target word is unchanged when read afterwards; the next request after release completes normally.
- WAIT_STATES=0. Back-to-back reads with req held high. -> ready high every other cycle; rdata matches previously written values.
